pdm_capture_ctrl: RTL and testbench
===================================

PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameter FIFO_DEPTH SHALL default to 4 and set the number of 16-bit PCM sample entries.
REQ-003 The ports SHALL be as follows:
- clk  in  1  system clock, 64 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- address  in  6  register offset
- data_in  in  32  write data
- data_write_n  in  2  11=none, 00=8b, 01=16b, 10=32b
- data_read_n  in  2  11=none, 00=8b, 01=16b, 10=32b
- data_out  out  32  read data, combinational from address
- data_ready  out  1  tied 1
- user_interrupt  out  1  level interrupt request
- pcm_in  in  16  filter output sample
- pcm_valid  in  1  one-cycle pulse per new sample, synchronous to clk
- filter_en  out  1  enables the PDM clock and filter
- filter_rst  out  1  synchronous clear of the filter integrators

Function
REQ-004 Register map:
- 0x00 CTRL: [0] START (write-1 pulse, reads 0); [1] STOP (write-1 pulse, reads 0); [2] CONT; [15:8] WARMUP; [31:16] BURST.
- 0x04 STATUS (read): [1:0] state; [4:2] fifo level; [5] OVF; [6] DONE. Writing 1 to bit 5 or bit 6 clears that bit.
- 0x08 DATA: read returns {16'h0, FIFO head}.
- 0x0C IRQCFG: [2:0] THRESH; [3] IE_LEVEL; [4] IE_DONE.
REQ-005 Byte lanes SHALL be written per width: [7:0] on any write, [15:8] on 16b/32b writes, [31:16] on 32b writes only.
REQ-006 The FSM SHALL have states IDLE=0, FLUSH=1, WARMUP=2 and CAPTURE=3.
REQ-007 In IDLE, START SHALL clear DONE, clear the sample counter and move to FLUSH on the next cycle.
REQ-008 In FLUSH, filter_rst SHALL be high for exactly 4 cycles, with filter_en high, then the FSM SHALL move to WARMUP.
REQ-009 In WARMUP, each pcm_valid SHALL be discarded and counted; after WARMUP discards the FSM SHALL move to CAPTURE.
REQ-010 If WARMUP=0, FLUSH SHALL go directly to CAPTURE.
REQ-011 In CAPTURE, each pcm_valid SHALL push pcm_in into the FIFO and increment the 16-bit sample counter.
REQ-012 When the counter reaches BURST with CONT=0, the FSM SHALL go to IDLE and set DONE.
REQ-013 BURST=0 or CONT=1 SHALL mean capture until STOP.
REQ-014 filter_en SHALL be high in FLUSH, WARMUP and CAPTURE, and low in IDLE.
REQ-015 STOP in any non-IDLE state SHALL return the FSM to IDLE next cycle without setting DONE; FIFO contents SHALL be retained.
REQ-016 START while the FSM is non-IDLE SHALL be ignored.
REQ-017 START and STOP written together SHALL act as STOP.
REQ-018 A 32-bit read of DATA with level>0 SHALL pop one entry at the end of that cycle; reads of other widths SHALL not pop.
REQ-019 A DATA read at level=0 SHALL return 0 and have no effect.
REQ-020 A push when full without a simultaneous pop SHALL drop the sample and set sticky OVF.
REQ-021 A simultaneous push and pop SHALL leave the level unchanged and never set OVF, including when the FIFO is full.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; level SHALL range 0..FIFO_DEPTH.
REQ-023 user_interrupt SHALL equal (IE_LEVEL & level>=THRESH & THRESH!=0) | (IE_DONE & DONE) | OVF.
REQ-024 pcm_valid in IDLE or FLUSH SHALL be ignored.
REQ-025 A pcm_valid in the same cycle as STOP SHALL be discarded.

Reset
REQ-026 On rst_n low, all registers SHALL clear asynchronously: state=IDLE, FIFO level=0, pointers=0, OVF=0, DONE=0, CTRL=0, IRQCFG=0, sample counter=0.
REQ-027 During reset, filter_en, filter_rst and user_interrupt SHALL be 0, and data_out SHALL be 0 for every address except 0x04, which reads 0.
REQ-028 Reset asserted mid-CAPTURE SHALL discard the FIFO contents and leave the block in IDLE after release.

Verification
REQ-029 Scenario: write CTRL=0x0003_0200 (WARMUP=2, BURST=3), START -> filter_rst high 4 cycles; first 2 pcm_valid discarded; next 3 (0x1111, 0x2222, 0x3333) read back in order; DONE=1; state=IDLE; filter_en=0.
REQ-030 Scenario: CONT=1, FIFO_DEPTH=4, 5 pcm_valid with no reads -> level=4, OVF=1, user_interrupt=1; reads return the first 4 samples; writing STATUS=0x20 clears OVF.
REQ-031 Scenario: FIFO full, pcm_valid in the same cycle as a 32-bit DATA read -> level stays 4, OVF=0, newest sample at the tail.
REQ-032 Scenario: THRESH=2, IE_LEVEL=1, capture 2 samples -> user_interrupt rises after the second push; one DATA read drops it.
REQ-033 Scenario: START then STOP during WARMUP -> IDLE next cycle, DONE=0, filter_en=0; a second START restarts from FLUSH.
REQ-034 Scenario: rst_n pulsed low mid-CAPTURE with level=3 -> STATUS=0 immediately; DATA read returns 0 after release.

Source files
------------

// File: rtl/pdm_capture_ctrl_if.sv
// Register-bus bundle for pdm_capture_ctrl: address/data/width strobes plus the
// read data, ready and interrupt lines returned by the block.
interface pdm_capture_ctrl_if;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready, user_interrupt
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready, user_interrupt
    );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// PDM capture controller: sequences filter flush/warm-up/capture and buffers
// decimated 16-bit PCM samples in a small FIFO behind a register interface.
module pdm_capture_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pdm_capture_ctrl_if.slave  bus,
    input  logic [15:0]        pcm_in,
    input  logic               pcm_valid,
    output logic               filter_en,
    output logic               filter_rst
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_DATA   = 6'h08;
    localparam logic [5:0] ADDR_IRQCFG = 6'h0C;

    localparam logic [1:0] WIDTH_NONE = 2'b11;
    localparam logic [1:0] WIDTH_16   = 2'b01;
    localparam logic [1:0] WIDTH_32   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_WARMUP  = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t state, state_next;

    // Configuration registers
    logic        ctrl_cont;
    logic [7:0]  ctrl_warmup;
    logic [15:0] ctrl_burst;
    logic [2:0]  irq_thresh;
    logic        irq_ie_level;
    logic        irq_ie_done;

    // Sequencing counters and sticky status
    logic [1:0]  flush_cnt;
    logic [7:0]  warm_cnt;
    logic [15:0] sample_cnt;
    logic        done;
    logic        ovf;

    // FIFO storage
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    // Bus decode
    logic wr_lane0, wr_lane1, wr_lane23;
    logic wr_ctrl, wr_status, wr_irqcfg;
    logic start_cmd, stop_cmd;

    assign wr_lane0  = bus.data_write_n != WIDTH_NONE;
    assign wr_lane1  = (bus.data_write_n == WIDTH_16) || (bus.data_write_n == WIDTH_32);
    assign wr_lane23 = bus.data_write_n == WIDTH_32;

    assign wr_ctrl   = wr_lane0 && (bus.address == ADDR_CTRL);
    assign wr_status = wr_lane0 && (bus.address == ADDR_STATUS);
    assign wr_irqcfg = wr_lane0 && (bus.address == ADDR_IRQCFG);

    assign start_cmd = wr_ctrl && bus.data_in[0];
    assign stop_cmd  = wr_ctrl && bus.data_in[1];

    // FIFO control
    logic fifo_full, fifo_empty;
    logic push, push_ok, pop, ovf_set;
    logic done_set, capture_start;

    assign fifo_full  = level == LVL_W'(FIFO_DEPTH);
    assign fifo_empty = level == '0;
    assign pop        = (bus.address == ADDR_DATA) && (bus.data_read_n == WIDTH_32) && !fifo_empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
    assign push_ok    = push && (!fifo_full || pop);
    assign ovf_set    = push && fifo_full && !pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_next    = state;
        filter_en     = 1'b0;
        filter_rst    = 1'b0;
        push          = 1'b0;
        done_set      = 1'b0;
        capture_start = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_cmd && !stop_cmd) begin
                    state_next    = ST_FLUSH;
                    capture_start = 1'b1;
                end
            end
            ST_FLUSH: begin
                filter_en  = 1'b1;
                filter_rst = 1'b1;
                if (stop_cmd) begin
                    state_next = ST_IDLE;
                end else if (flush_cnt == 2'd3) begin
                    state_next = (ctrl_warmup == 8'd0) ? ST_CAPTURE : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                filter_en = 1'b1;
                if (stop_cmd) begin
                    state_next = ST_IDLE;
                end else if (pcm_valid && (warm_cnt + 8'd1 == ctrl_warmup)) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                filter_en = 1'b1;
                if (stop_cmd) begin
                    state_next = ST_IDLE;
                end else if (pcm_valid) begin
                    push = 1'b1;
                    if (!ctrl_cont && (ctrl_burst != 16'd0) && (sample_cnt + 16'd1 == ctrl_burst)) begin
                        state_next = ST_IDLE;
                        done_set   = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cont    <= 1'b0;
            ctrl_warmup  <= '0;
            ctrl_burst   <= '0;
            irq_thresh   <= '0;
            irq_ie_level <= 1'b0;
            irq_ie_done  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_cont <= bus.data_in[2];
            if (wr_ctrl && wr_lane1) ctrl_warmup <= bus.data_in[15:8];
            if (wr_ctrl && wr_lane23) ctrl_burst <= bus.data_in[31:16];
            if (wr_irqcfg) begin
                irq_thresh   <= bus.data_in[2:0];
                irq_ie_level <= bus.data_in[3];
                irq_ie_done  <= bus.data_in[4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt  <= '0;
            warm_cnt   <= '0;
            sample_cnt <= '0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            flush_cnt <= (state == ST_FLUSH) ? flush_cnt + 2'd1 : 2'd0;

            if (state != ST_WARMUP) warm_cnt <= '0;
            else if (pcm_valid)     warm_cnt <= warm_cnt + 8'd1;

            if (capture_start) sample_cnt <= '0;
            else if (push)     sample_cnt <= sample_cnt + 16'd1;

            // A new event wins over a same-cycle software clear so it is never lost.
            if (done_set)                                         done <= 1'b1;
            else if (capture_start || (wr_status && bus.data_in[6])) done <= 1'b0;

            if (ovf_set)                           ovf <= 1'b1;
            else if (wr_status && bus.data_in[5]) ovf <= 1'b0;
        end
    end

    // NOTE: sample storage has no reset; level/pointers gate every read, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= pcm_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            unique case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_CTRL:   bus.data_out = {ctrl_burst, ctrl_warmup, 5'd0, ctrl_cont, 2'd0};
            ADDR_STATUS: bus.data_out = {25'd0, done, ovf, 3'(level), state};
            ADDR_DATA:   if (!fifo_empty) bus.data_out = {16'h0000, mem[rd_ptr]};
            ADDR_IRQCFG: bus.data_out = {27'd0, irq_ie_done, irq_ie_level, irq_thresh};
            default:     bus.data_out = '0;
        endcase
    end

    logic level_hit;
    assign level_hit = irq_ie_level && (irq_thresh != 3'd0) && (32'(level) >= 32'(irq_thresh));

    assign bus.user_interrupt = level_hit || (irq_ie_done && done) || ovf;
    assign bus.data_ready     = 1'b1;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl: register access, capture sequencing,
// FIFO overflow/simultaneous push-pop, interrupts and mid-capture reset.
module tb_pdm_capture_ctrl;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_DATA   = 6'h08;
    localparam logic [5:0] A_IRQCFG = 6'h0C;
    localparam logic [1:0] W8   = 2'b00;
    localparam logic [1:0] W16  = 2'b01;
    localparam logic [1:0] W32  = 2'b10;
    localparam logic [1:0] NONE = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pcm_in;
    logic        pcm_valid;
    logic        filter_en;
    logic        filter_rst;

    int n_checks = 0;
    int n_errors = 0;

    pdm_capture_ctrl_if bus ();

    pdm_capture_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pcm_in     (pcm_in),
        .pcm_valid  (pcm_valid),
        .filter_en  (filter_en),
        .filter_rst (filter_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] width);
        bus.address      = addr;
        bus.data_in      = data;
        bus.data_write_n = width;
        tick();
        bus.data_write_n = NONE;
    endtask

    task automatic bus_read(input logic [5:0] addr, input logic [1:0] width, output logic [31:0] data);
        bus.address     = addr;
        bus.data_read_n = width;
        #1;
        data = bus.data_out;
        tick();
        bus.data_read_n = NONE;
    endtask

    task automatic peek(input logic [5:0] addr, output logic [31:0] data);
        bus.address = addr;
        #1;
        data = bus.data_out;
    endtask

    task automatic check_reg(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        peek(addr, d);
        check(tag, d, exp);
    endtask

    task automatic check_read(input string tag, input logic [1:0] width, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(A_DATA, width, d);
        check(tag, d, exp);
    endtask

    task automatic pcm_push(input logic [15:0] value);
        pcm_in    = value;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        rst_n            = 1'b0;
        pcm_in           = '0;
        pcm_valid        = 1'b0;
        bus.address      = '0;
        bus.data_in      = '0;
        bus.data_write_n = NONE;
        bus.data_read_n  = NONE;

        // Reset state, sampled while reset is still asserted
        repeat (2) @(posedge clk);
        #1;
        check_reg("rst_status", A_STATUS, 32'h0);
        check_reg("rst_ctrl", A_CTRL, 32'h0);
        check_reg("rst_data", A_DATA, 32'h0);
        check("rst_filter_en", {31'd0, filter_en}, 32'd0);
        check("rst_filter_rst", {31'd0, filter_rst}, 32'd0);
        check("rst_irq", {31'd0, bus.user_interrupt}, 32'd0);
        check("data_ready", {31'd0, bus.data_ready}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Burst of 3 after 2 warm-up discards
        bus_write(A_CTRL, 32'h0003_0200, W32);
        check_reg("ctrl_rb", A_CTRL, 32'h0003_0200);
        bus_write(A_CTRL, 32'h0003_0201, W32);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("flush_rst_%0d", i), {31'd0, filter_rst}, 32'd1);
            check($sformatf("flush_en_%0d", i), {31'd0, filter_en}, 32'd1);
            tick();
        end
        check("flush_end", {31'd0, filter_rst}, 32'd0);
        check_reg("warmup_state", A_STATUS, 32'h02);
        pcm_push(16'hAAAA);
        check_reg("warmup_1", A_STATUS, 32'h02);
        pcm_push(16'hBBBB);
        check_reg("capture_entry", A_STATUS, 32'h03);
        pcm_push(16'h1111);
        pcm_push(16'h2222);
        check_reg("capture_lvl2", A_STATUS, 32'h0B);
        pcm_push(16'h3333);
        check_reg("burst_done", A_STATUS, 32'h4C);
        check("burst_filter_en", {31'd0, filter_en}, 32'd0);
        check("done_irq_masked", {31'd0, bus.user_interrupt}, 32'd0);
        bus_write(A_IRQCFG, 32'h10, W8);
        check("done_irq", {31'd0, bus.user_interrupt}, 32'd1);
        bus_write(A_IRQCFG, 32'h00, W8);
        pcm_push(16'h5555);
        check_reg("idle_pcm_ignored", A_STATUS, 32'h4C);
        check_read("burst_rd0", W32, 32'h1111);
        check_read("burst_rd1", W32, 32'h2222);
        check_read("burst_rd2", W32, 32'h3333);
        check_read("empty_rd", W32, 32'h0);
        check_reg("empty_status", A_STATUS, 32'h40);
        bus_write(A_STATUS, 32'h40, W8);
        check_reg("done_clr", A_STATUS, 32'h00);

        // Byte-lane write enables
        bus_write(A_CTRL, 32'h0000_0000, W32);
        bus_write(A_CTRL, 32'h1234_5600, W16);
        check_reg("lane_w16", A_CTRL, 32'h0000_5600);
        bus_write(A_CTRL, 32'hFFFF_FF04, W8);
        check_reg("lane_w8", A_CTRL, 32'h0000_5604);
        check_reg("lane_no_start", A_STATUS, 32'h00);

        // STOP during warm-up, restart, START ignored while busy, START+STOP
        bus_write(A_CTRL, 32'h0003_0201, W32);
        repeat (4) tick();
        check_reg("ws_warmup", A_STATUS, 32'h02);
        bus_write(A_CTRL, 32'h0003_0202, W32);
        check_reg("ws_stopped", A_STATUS, 32'h00);
        check("ws_filter_off", {31'd0, filter_en}, 32'd0);
        bus_write(A_CTRL, 32'h0003_0201, W32);
        check_reg("ws_restart", A_STATUS, 32'h01);
        check("ws_restart_rst", {31'd0, filter_rst}, 32'd1);
        bus_write(A_CTRL, 32'h0003_0201, W32);
        repeat (2) tick();
        check("busy_start_rst", {31'd0, filter_rst}, 32'd1);
        tick();
        check_reg("busy_start_ignored", A_STATUS, 32'h02);
        bus_write(A_CTRL, 32'h0003_0202, W32);
        bus_write(A_CTRL, 32'h0003_0203, W32);
        check_reg("start_stop_idle", A_STATUS, 32'h00);
        check("start_stop_en", {31'd0, filter_en}, 32'd0);

        // Continuous capture overflow, WARMUP=0 skips straight to CAPTURE
        bus_write(A_CTRL, 32'h0000_0005, W32);
        repeat (4) tick();
        check_reg("cont_capture", A_STATUS, 32'h03);
        for (int i = 1; i <= 5; i++) pcm_push(16'h0A00 + 16'(i));
        check_reg("ovf_status", A_STATUS, 32'h33);
        check("ovf_irq", {31'd0, bus.user_interrupt}, 32'd1);
        for (int i = 1; i <= 4; i++) check_read($sformatf("ovf_rd%0d", i), W32, 32'h0A00 + 32'(i));
        check_reg("ovf_drained", A_STATUS, 32'h23);
        bus_write(A_STATUS, 32'h20, W8);
        check_reg("ovf_clr", A_STATUS, 32'h03);
        check("ovf_clr_irq", {31'd0, bus.user_interrupt}, 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) pcm_push(16'hB000 + 16'(i));
        check_reg("full_status", A_STATUS, 32'h13);
        pcm_in    = 16'hB005;
        pcm_valid = 1'b1;
        bus_read(A_DATA, W32, d);
        pcm_valid = 1'b0;
        check("pushpop_head", d, 32'hB001);
        check_reg("pushpop_status", A_STATUS, 32'h13);
        bus_write(A_CTRL, 32'h0000_0006, W32);
        check_reg("stop_retains", A_STATUS, 32'h10);
        check_read("rd16_nopop", W16, 32'hB002);
        check_reg("rd16_level", A_STATUS, 32'h10);
        for (int i = 2; i <= 5; i++) check_read($sformatf("tail_rd%0d", i), W32, 32'hB000 + 32'(i));
        check_reg("tail_empty", A_STATUS, 32'h00);

        // Sample arriving with STOP is discarded
        bus_write(A_CTRL, 32'h0000_0005, W32);
        repeat (4) tick();
        pcm_in    = 16'hC000;
        pcm_valid = 1'b1;
        bus_write(A_CTRL, 32'h0000_0006, W32);
        pcm_valid = 1'b0;
        check_reg("stop_discard", A_STATUS, 32'h00);

        // Level interrupt at THRESH=2
        bus_write(A_IRQCFG, 32'h0A, W8);
        bus_write(A_CTRL, 32'h0000_0005, W32);
        repeat (4) tick();
        pcm_push(16'hD001);
        check("lvl_irq_1", {31'd0, bus.user_interrupt}, 32'd0);
        pcm_push(16'hD002);
        check("lvl_irq_2", {31'd0, bus.user_interrupt}, 32'd1);
        check_read("lvl_rd", W32, 32'hD001);
        check("lvl_irq_drop", {31'd0, bus.user_interrupt}, 32'd0);
        bus_write(A_CTRL, 32'h0000_0006, W32);
        check_read("lvl_rd2", W32, 32'hD002);
        bus_write(A_IRQCFG, 32'h00, W8);

        // Reset in the middle of a capture
        bus_write(A_CTRL, 32'h0000_0005, W32);
        repeat (4) tick();
        pcm_push(16'hE001);
        pcm_push(16'hE002);
        pcm_push(16'hE003);
        check_reg("pre_reset", A_STATUS, 32'h0F);
        rst_n = 1'b0;
        #1;
        check_reg("mid_reset_status", A_STATUS, 32'h00);
        check("mid_reset_en", {31'd0, filter_en}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_read("post_reset_data", W32, 32'h0);
        check_reg("post_reset_status", A_STATUS, 32'h00);
        check_reg("post_reset_ctrl", A_CTRL, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
